// File: rtl/fnd_pkg.sv
// Shared constants, FSM encoding and segment decoder for the FND scan path.
package fnd_pkg;
  localparam int FND_DIGITS = 4;
  localparam int VALUE_W    = 14;
  localparam int BCD_W      = 16;
  localparam int VALUE_MAX  = 9999;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with start/ready handshake; owns the
// display BCD/dp registers, which it commits atomically in DONE.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  input  logic [FND_DIGITS-1:0] dp_in,
  output logic                  ready,
  output logic [BCD_W-1:0]      bcd,
  output logic [FND_DIGITS-1:0] dp_out
);
  conv_state_t           state, state_next;
  logic [VALUE_W-1:0]    bin;
  logic [BCD_W-1:0]      work, adj;
  logic [3:0]            step_cnt;
  logic [FND_DIGITS-1:0] dp_cap;
  logic [VALUE_W-1:0]    value_sat;

  assign ready     = (state == IDLE);
  assign value_sat = (value > VALUE_W'(VALUE_MAX)) ? VALUE_W'(VALUE_MAX) : value;

  always_comb begin
    adj = work;
    for (int i = 0; i < FND_DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = work[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? CONVERT : IDLE;
      CONVERT: state_next = (step_cnt == 4'd13) ? DONE : CONVERT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bin      <= '0;
      work     <= '0;
      step_cnt <= 4'd0;
      dp_cap   <= '0;
      bcd      <= '0;
      dp_out   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            bin      <= value_sat;
            work     <= '0;
            step_cnt <= 4'd0;
            dp_cap   <= dp_in;
          end
        end
        CONVERT: begin
          work     <= {adj[BCD_W-2:0], bin[VALUE_W-1]};
          bin      <= {bin[VALUE_W-2:0], 1'b0};
          step_cnt <= step_cnt + 4'd1;
        end
        DONE: begin
          bcd    <= work;
          dp_out <= dp_cap;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND driver: BCD conversion plus prescaled digit scan.
// Optional leading-zero blanking via FND_BLANK_LEADING_ZERO_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int CNT_W    = 17
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [VALUE_W-1:0]    i_value,
  input  logic [FND_DIGITS-1:0] i_dp,
  output logic                  o_ready,
  output logic                  o_scan_tick,
  output logic [FND_DIGITS-1:0] o_fnd_com,
  output logic [7:0]            o_fnd_font
);
  logic [CNT_W-1:0]      prescaler;
  logic [1:0]            idx;
  logic [BCD_W-1:0]      disp_bcd;
  logic [FND_DIGITS-1:0] disp_dp;
  logic [3:0]            digit;
  logic [6:0]            seg;
  logic [FND_DIGITS-1:0] com_next;
  logic [7:0]            font_next;

  bin2bcd_seq u_conv (
    .clk    (i_clk),
    .reset  (i_reset),
    .start  (i_load),
    .value  (i_value),
    .dp_in  (i_dp),
    .ready  (o_ready),
    .bcd    (disp_bcd),
    .dp_out (disp_dp)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescaler   <= '0;
      idx         <= 2'd0;
      o_scan_tick <= 1'b0;
    end else if (i_enable) begin
      if (prescaler == CNT_W'(SCAN_DIV - 1)) begin
        prescaler   <= '0;
        idx         <= idx + 2'd1;
        o_scan_tick <= 1'b1;
      end else begin
        prescaler   <= prescaler + CNT_W'(1);
        o_scan_tick <= 1'b0;
      end
    end else begin
      prescaler   <= '0;
      o_scan_tick <= 1'b0;
    end
  end

  assign digit = disp_bcd[{idx, 2'b00} +: 4];

`ifdef FND_BLANK_LEADING_ZERO_EN
  logic [FND_DIGITS-1:0] blank_mask;
  // A digit is blank only when it and every more significant digit are zero.
  always_comb begin
    blank_mask[3] = (disp_bcd[15:12] == 4'd0);
    blank_mask[2] = blank_mask[3] && (disp_bcd[11:8] == 4'd0);
    blank_mask[1] = blank_mask[2] && (disp_bcd[7:4] == 4'd0);
    blank_mask[0] = 1'b0;
    if (blank_mask[idx]) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg_decode(digit);
    end
  end
`else
  assign seg = seg_decode(digit);
`endif

  always_comb begin
    com_next  = 4'b1111;
    font_next = 8'hFF;
    if (i_enable) begin
      com_next  = ~(4'b0001 << idx);
      font_next = {~disp_dp[idx], seg};
    end else begin
      com_next  = 4'b1111;
      font_next = 8'hFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fnd_com  <= 4'b1111;
      o_fnd_font <= 8'hFF;
    end else begin
      o_fnd_com  <= com_next;
      o_fnd_font <= font_next;
    end
  end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: directed test-plan steps plus
// random traffic, compared every cycle against a decimal-arithmetic model.
module tb_fnd_scan_controller;
  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 3;

  logic        i_clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_load;
  logic [13:0] i_value;
  logic [3:0]  i_dp;
  logic        o_ready;
  logic        o_scan_tick;
  logic [3:0]  o_fnd_com;
  logic [7:0]  o_fnd_font;

  int checks = 0;
  int errors = 0;

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_load      (i_load),
    .i_value     (i_value),
    .i_dp        (i_dp),
    .o_ready     (o_ready),
    .o_scan_tick (o_scan_tick),
    .o_fnd_com   (o_fnd_com),
    .o_fnd_font  (o_fnd_font)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model state: displayed decimal value, scan slot, pending load.
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         m_cnt = 0, m_idx = 0, m_busy = 0, m_val = 0, m_pend_val = 0;
  logic [3:0] m_dp = 4'd0, m_pend_dp = 4'd0;
  logic       m_tick = 1'b0;
  logic [3:0] m_com = 4'hF;
  logic [7:0] m_font = 8'hFF;

  function automatic logic [7:0] exp_font(int v, logic [3:0] dp, int k);
    int p;
    logic [7:0] s;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    s = seg_tab[(v / p) % 10];
`ifdef FND_BLANK_LEADING_ZERO_EN
    if (k > 0 && v < p) s = 8'hFF;
`endif
    return {~dp[k], s[6:0]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (i_reset) begin
      m_cnt = 0; m_idx = 0; m_tick = 1'b0; m_busy = 0; m_val = 0; m_dp = 4'd0;
      m_com = 4'hF; m_font = 8'hFF;
    end else begin
      if (i_enable) begin
        m_com  = ~(4'b0001 << m_idx);
        m_font = exp_font(m_val, m_dp, m_idx);
        if (m_cnt == SCAN_DIV - 1) begin
          m_cnt = 0; m_idx = (m_idx + 1) % 4; m_tick = 1'b1;
        end else begin
          m_cnt++; m_tick = 1'b0;
        end
      end else begin
        m_com = 4'hF; m_font = 8'hFF; m_cnt = 0; m_tick = 1'b0;
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_val = m_pend_val; m_dp = m_pend_dp;
        end
      end else if (i_load) begin
        m_pend_val = (int'(i_value) > 9999) ? 9999 : int'(i_value);
        m_pend_dp  = i_dp;
        m_busy     = 15;
      end
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    #1;
    chk("ready", {7'd0, o_ready}, {7'd0, (m_busy == 0)});
    chk("tick",  {7'd0, o_scan_tick}, {7'd0, m_tick});
    chk("com",   {4'd0, o_fnd_com}, {4'd0, m_com});
    chk("font",  o_fnd_font, m_font);
  endtask

  task automatic load(input int v, input logic [3:0] dp);
    i_value = 14'(v); i_dp = dp; i_load = 1'b1;
    cycle();
    i_load = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && m_busy != 0; k++) cycle();
    chk("wait_ready", {7'd0, o_ready}, 8'd1);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_load = 1'b0; i_value = 14'd0; i_dp = 4'd0;
    cycle(); cycle();
    chk("rst_com",   {4'd0, o_fnd_com}, 8'h0F);
    chk("rst_font",  o_fnd_font, 8'hFF);
    chk("rst_ready", {7'd0, o_ready}, 8'd1);
    chk("rst_tick",  {7'd0, o_scan_tick}, 8'd0);
    i_reset = 1'b0; i_enable = 1'b1;

    load(1234, 4'b0000);
    repeat (14) begin
      chk("busy_1234", {7'd0, o_ready}, 8'd0);
      cycle();
    end
    wait_ready();
    repeat (20) cycle();

    load(12345, 4'b0000); wait_ready(); repeat (12) cycle();
    load(0, 4'b0010);     wait_ready(); repeat (12) cycle();

    load(5, 4'b0000); cycle(); cycle();
    load(7, 4'b0000); wait_ready(); repeat (10) cycle();
    load(7, 4'b0000); wait_ready(); repeat (10) cycle();

    for (int k = 0; k < 40 && !(m_idx == 2 && m_cnt == 1); k++) cycle();
    chk("at_idx2", 8'(m_idx), 8'd2);
    i_enable = 1'b0; repeat (6) cycle();
    i_enable = 1'b1; repeat (10) cycle();

    load(42, 4'b0000); wait_ready(); repeat (12) cycle();

    load(1234, 4'b0101); repeat (5) cycle();
    i_reset = 1'b1; cycle();
    i_reset = 1'b0; repeat (8) cycle();

    repeat (600) begin
      i_load  = ($urandom % 6) == 0;
      i_value = 14'($urandom_range(0, 16383));
      i_dp    = 4'($urandom);
      if ($urandom % 40 == 0) i_enable = ~i_enable;
      i_reset = ($urandom % 250) == 0;
      cycle();
    end
    i_reset = 1'b0; i_load = 1'b0; i_enable = 1'b1;
    repeat (10) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
